ad9866_spi_responder: RTL and testbench
=======================================

Name: ad9866_spi_responder

Overview:
- Synthesizable SPI responder (slave) for the 4-wire AD9866 register-write protocol driven on rffe_ad9866_sen_n / sclk / sdio.
- Decodes 16-bit frames, maintains a 32x8 shadow register file and emits per-write strobes.
- Used in loopback and bench builds to stand in for the AD9866 and to check init and gain traffic from the codec controller.
- Runs in the clk_ad9866 domain and oversamples SCLK (SCLK period is at least 4 clk_ad9866 cycles).

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied identically to sen_n, sclk and sdio (minimum 1).
- NREGS, 32, number of shadow registers; address field is 5 bits.

Ports:
- clk_ad9866  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rffe_ad9866_sen_n  input  1  SPI chip enable, active low.
- rffe_ad9866_sclk  input  1  SPI clock; idles low.
- rffe_ad9866_sdio  input  1  serial data, MSB first.
- rffe_ad9866_sdo  output  1  serial read data.
- wr_stb  output  1  one-cycle pulse on each committed write.
- wr_addr  output  5  address of the last committed write.
- wr_data  output  8  data of the last committed write.
- rd_addr  input  5  bench lookup address.
- rd_data  output  8  combinational read of shadow[rd_addr].
- rx_gain  output  6  shadow[0x09][5:0].
- tx_gain  output  4  shadow[0x0a][3:0].
- frame_err  output  1  sticky flag, set on a short or overlong frame.
- frame_cnt  output  16  count of committed writes; wraps at 0xFFFF to 0.

Behaviour:
- Clock and reset: one clock, clk_ad9866. Reset is asynchronous and active-low on rst_n. Reset clears every flop.
- Reset values: shadow regs 0x00, wr_stb 0, wr_addr 0, wr_data 0, frame_err 0, frame_cnt 0, sdo 0, state IDLE.
- Input sampling: sen_n, sclk and sdio pass through SYNC_STAGES flops.
  - rise = sclk_s & ~sclk_q.
  - fall = ~sclk_s & sclk_q.
  - sdio is sampled on rise. Its pipeline is equal in length to sclk's, so data and edge stay aligned.
- Frame format, MSB first:
  - bit15 = R/W (0 = write, 1 = read).
  - bits14:13 = width; must be 00, otherwise the frame is an error.
  - bits12:8 = address.
  - bits7:0 = data.
- FSM states: IDLE, SHIFT, HOLD, ERR.
  - IDLE: on sen_s falling, bitcnt=0, shift=0, go to SHIFT.
  - SHIFT: on rise, shift = {shift[14:0], sdio_s} and bitcnt += 1.
    - When bitcnt reaches 16, go to HOLD.
    - If sen_s goes high with bitcnt < 16, set frame_err and go to IDLE (no commit).
  - HOLD: waits for sen_s high.
    - Any rise in HOLD sets frame_err and goes to ERR.
    - On sen_s rising with a write frame and width 00: shadow[addr] = data, wr_addr/wr_data updated, wr_stb = 1 for exactly one cycle, frame_cnt += 1.
    - A width field other than 00 sets frame_err and gives no commit.
    - Return to IDLE.
  - ERR: ignores all edges until sen_s is high, then goes to IDLE. No commit.
- Latency: wr_stb asserts SYNC_STAGES+1 cycles after the raw sen_n rising edge.
- Commit ordering: shadow, rx_gain and tx_gain reflect the new value in the same cycle wr_stb is high.
- Back-to-back frames: sen_n may fall again on the cycle after the commit (the master gives 1 IDLE cycle); the responder must catch it.
- rst_n asserted mid-frame: the frame is discarded and the shadow returns to 0.
- Only frame_err is sticky; it clears only on reset.
- Read frames (bit15 = 1) are never committed.

Optional Feature:
- Macro: AD9866_SPI_READBACK_EN.
- Defined: on a read frame, once bitcnt = 8 (address latched), sdo drives shadow[addr][7-k] after each fall for k = 0..7, MSB first. sdo returns to 0 in IDLE.
- Undefined: sdo is tied 0; read frames are parsed and discarded with no error.

Test Plan:
- Write 0x097F via a master-timed frame (sclk 2 high / 2 low) -> one wr_stb; wr_addr=0x09, wr_data=0x7F; rx_gain=0x3F; frame_cnt=1.
- Write 0x0A4F -> tx_gain=0xF; shadow[0x0a]=0x4F; rd_addr=0x0a gives rd_data=0x4F.
- Full init burst of 9 back-to-back writes (0x0654, 0x0720, 0x0B00, 0x0C43, 0x0D03, 0x0E81, 0x1080, 0x1100, 0x1200) -> 9 strobes; frame_cnt=9; all shadows match.
- sen_n raised after 10 bits -> frame_err=1, no wr_stb, shadow unchanged; a following valid frame 0x0155 still commits.
- 17 SCLK rises in one frame -> frame_err=1, no commit. A frame with width bits 01 -> frame_err=1, no commit.
- With AD9866_SPI_READBACK_EN, shadow[0x0c]=0x43 and read frame 0x8C00 -> sdo serializes 0,1,0,0,0,0,1,1; no wr_stb.

Source files
------------

// File: rtl/ad9866_spi_responder.sv
// AD9866 SPI responder: decodes 16-bit register-write frames into a 32x8 shadow file with per-write strobes.
// Latency: wr_stb rises SYNC_STAGES+1 clk_ad9866 cycles after the raw sen_n rising edge.
// Backpressure: none; the SPI master is never stalled. Optional readback on sdo with AD9866_SPI_READBACK_EN.
module ad9866_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NREGS       = 32
) (
    input  logic        clk_ad9866,
    input  logic        rst_n,
    input  logic        rffe_ad9866_sen_n,
    input  logic        rffe_ad9866_sclk,
    input  logic        rffe_ad9866_sdio,
    output logic        rffe_ad9866_sdo,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [5:0]  rx_gain,
    output logic [3:0]  tx_gain,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Synchronizer chains: all three inputs see the same depth so data stays aligned with the sclk edge.
    logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
    logic                   sen_q, sen_d;
    logic                   sclk_q, sclk_d;

    logic sen_s, sclk_s, sdio_s;
    logic rise, sen_fall;

    state_t      state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  shadow_q [NREGS];
    logic [7:0]  shadow_d [NREGS];
    logic        wr_stb_q, wr_stb_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

`ifdef AD9866_SPI_READBACK_EN
    logic       fall;
    logic       rb_rd_q, rb_rd_d;
    logic [4:0] rb_addr_q, rb_addr_d;
    logic       sdo_q, sdo_d;
    logic [7:0] rb_byte;
    logic [2:0] rb_sel;
`endif

    // Shift each raw input one stage deeper into its synchronizer and keep one extra copy for edge detection.
    always_comb begin
        sen_sync_d  = (sen_sync_q << 1) | SYNC_STAGES'(rffe_ad9866_sen_n);
        sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(rffe_ad9866_sclk);
        sdio_sync_d = (sdio_sync_q << 1) | SYNC_STAGES'(rffe_ad9866_sdio);
        sen_d       = sen_sync_q[SYNC_STAGES-1];
        sclk_d      = sclk_sync_q[SYNC_STAGES-1];
    end

    assign sen_s    = sen_sync_q[SYNC_STAGES-1];
    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign sdio_s   = sdio_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_q;
    assign sen_fall = ~sen_s & sen_q;

`ifdef AD9866_SPI_READBACK_EN
    assign fall    = ~sclk_s & sclk_q;
    assign rb_byte = (int'(rb_addr_q) < NREGS) ? shadow_q[rb_addr_q] : 8'h00;
    // bitcnt 8..15 selects byte bits 7..0, so the MSB leaves first.
    assign rb_sel  = 3'(4'd15 - bitcnt_q[3:0]);
`endif

    // Frame FSM: shift on sclk rise, validate framing while sen_n is high, commit writes to the shadow file.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
`ifdef AD9866_SPI_READBACK_EN
        rb_rd_d   = rb_rd_q;
        rb_addr_d = rb_addr_q;
        sdo_d     = sdo_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef AD9866_SPI_READBACK_EN
                sdo_d = 1'b0;
`endif
                if (sen_fall) begin
                    bitcnt_d = 5'd0;
                    shift_d  = 16'h0000;
                    state_d  = SHIFT;
`ifdef AD9866_SPI_READBACK_EN
                    rb_rd_d  = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (sen_s) begin
                    // Chip enable released before all 16 bits arrived.
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (rise) begin
                    shift_d  = {shift_q[14:0], sdio_s};
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd15) begin
                        state_d = HOLD;
                    end
`ifdef AD9866_SPI_READBACK_EN
                    // The 8th bit completes R/W, width and address.
                    if (bitcnt_q == 5'd7) begin
                        rb_rd_d   = shift_q[6];
                        rb_addr_d = {shift_q[3:0], sdio_s};
                    end
`endif
                end
`ifdef AD9866_SPI_READBACK_EN
                else if (fall && rb_rd_q && (bitcnt_q >= 5'd8)) begin
                    sdo_d = rb_byte[rb_sel];
                end
`endif
            end
            HOLD: begin
                if (rise) begin
                    // A 17th clock makes the frame overlong.
                    frame_err_d = 1'b1;
                    state_d     = ERR;
                end else if (sen_s) begin
                    if (shift_q[14:13] != 2'b00) begin
                        frame_err_d = 1'b1;
                    end else if (!shift_q[15]) begin
                        if (int'(shift_q[12:8]) < NREGS) begin
                            shadow_d[shift_q[12:8]] = shift_q[7:0];
                        end
                        wr_stb_d    = 1'b1;
                        wr_addr_d   = shift_q[12:8];
                        wr_data_d   = shift_q[7:0];
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (sen_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; every flop clears on reset, including the shadow file.
    always_ff @(posedge clk_ad9866 or negedge rst_n) begin
        if (!rst_n) begin
            sen_sync_q  <= '0;
            sclk_sync_q <= '0;
            sdio_sync_q <= '0;
            sen_q       <= 1'b0;
            sclk_q      <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 5'd0;
            shift_q     <= 16'h0000;
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= 8'h00;
            end
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 16'h0000;
`ifdef AD9866_SPI_READBACK_EN
            rb_rd_q     <= 1'b0;
            rb_addr_q   <= 5'd0;
            sdo_q       <= 1'b0;
`endif
        end else begin
            sen_sync_q  <= sen_sync_d;
            sclk_sync_q <= sclk_sync_d;
            sdio_sync_q <= sdio_sync_d;
            sen_q       <= sen_d;
            sclk_q      <= sclk_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef AD9866_SPI_READBACK_EN
            rb_rd_q     <= rb_rd_d;
            rb_addr_q   <= rb_addr_d;
            sdo_q       <= sdo_d;
`endif
        end
    end

`ifdef AD9866_SPI_READBACK_EN
    assign rffe_ad9866_sdo = sdo_q;
`else
    assign rffe_ad9866_sdo = 1'b0;
`endif

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign rd_data   = (int'(rd_addr) < NREGS) ? shadow_q[rd_addr] : 8'h00;
    assign rx_gain   = shadow_q[9][5:0];
    assign tx_gain   = shadow_q[10][3:0];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for ad9866_spi_responder: drives master-timed SPI frames and checks the shadow file.
// Latency: frames take 4 clk_ad9866 cycles per SCLK bit plus framing gaps.
// Backpressure: none; stimulus runs open loop with fixed cycle budgets.
module tb_ad9866_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sen_n;
    logic        sclk;
    logic        sdio;
    logic        sdo;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [5:0]  rx_gain;
    logic [3:0]  tx_gain;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int stb_count = 0;
    int last_lat;
    logic       sdo_cap [32];
    logic [5:0] rx_at_stb;
    logic [7:0] rd_at_stb;

    localparam logic [15:0] BURST [9] = '{16'h0654, 16'h0720, 16'h0B00, 16'h0C43, 16'h0D03,
                                          16'h0E81, 16'h1080, 16'h1100, 16'h1200};

    ad9866_spi_responder #(.SYNC_STAGES(2), .NREGS(32)) dut (
        .clk_ad9866        (clk),
        .rst_n             (rst_n),
        .rffe_ad9866_sen_n (sen_n),
        .rffe_ad9866_sclk  (sclk),
        .rffe_ad9866_sdio  (sdio),
        .rffe_ad9866_sdo   (sdo),
        .wr_stb            (wr_stb),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .rx_gain           (rx_gain),
        .tx_gain           (tx_gain),
        .frame_err         (frame_err),
        .frame_cnt         (frame_cnt)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts commits and snapshots outputs in the strobe cycle.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_count++;
            rx_at_stb = rx_gain;
            rd_at_stb = rd_data;
        end
    end

    task automatic apply_reset();
        sen_n = 1'b1; sclk = 1'b0; sdio = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Master: sclk 2 low / 2 high per bit, MSB first, bits past 16 are zero; sdo sampled before each fall.
    task automatic send_frame(input logic [15:0] w, input int nbits, input int gap);
        last_lat = 0;
        sen_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdio = (i < 16) ? w[15-i] : 1'b0;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            if (i < 32) sdo_cap[i] = sdo;
            sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        sen_n = 1'b1;
        for (int c = 1; c <= gap; c++) begin
            @(negedge clk);
            if (wr_stb === 1'b1 && last_lat == 0) last_lat = c;
        end
        sdio = 1'b0;
    endtask

    task automatic test_reset();
        sen_n = 1'b1; sclk = 1'b0; sdio = 1'b0; rst_n = 1'b0; rd_addr = 5'h0c;
        repeat (3) @(negedge clk);
        checks++; if (wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
        checks++; if (wr_addr !== 5'h00 || wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_fields got=%h/%h exp=00/00", wr_addr, wr_data); end
        checks++; if (frame_cnt !== 16'h0000) begin failures++; $display("FAIL reset_frame_cnt got=%h exp=0000", frame_cnt); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdo); end
        checks++; if (rd_data !== 8'h00 || rx_gain !== 6'h00 || tx_gain !== 4'h0) begin failures++; $display("FAIL reset_shadow got=%h/%h/%h exp=00/00/0", rd_data, rx_gain, tx_gain); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_rx_gain();
        int s0;
        s0 = stb_count; rd_addr = 5'h09;
        send_frame(16'h097F, 16, 8);
        checks++; if (stb_count - s0 != 1) begin failures++; $display("FAIL rx_stb_count got=%0d exp=1", stb_count - s0); end
        checks++; if (last_lat != 3) begin failures++; $display("FAIL rx_stb_latency got=%0d exp=3", last_lat); end
        checks++; if (wr_addr !== 5'h09 || wr_data !== 8'h7F) begin failures++; $display("FAIL rx_wr_fields got=%h/%h exp=09/7f", wr_addr, wr_data); end
        checks++; if (rx_gain !== 6'h3F) begin failures++; $display("FAIL rx_gain got=%h exp=3f", rx_gain); end
        checks++; if (rx_at_stb !== 6'h3F || rd_at_stb !== 8'h7F) begin failures++; $display("FAIL rx_commit_same_cycle got=%h/%h exp=3f/7f", rx_at_stb, rd_at_stb); end
        checks++; if (frame_cnt !== 16'd1 || frame_err !== 1'b0) begin failures++; $display("FAIL rx_cnt_err got=%0d/%b exp=1/0", frame_cnt, frame_err); end
    endtask

    task automatic test_write_tx_gain();
        send_frame(16'h0A4F, 16, 8);
        rd_addr = 5'h0a; #1;
        checks++; if (tx_gain !== 4'hF) begin failures++; $display("FAIL tx_gain got=%h exp=f", tx_gain); end
        checks++; if (rd_data !== 8'h4F) begin failures++; $display("FAIL tx_shadow got=%h exp=4f", rd_data); end
        checks++; if (rx_gain !== 6'h3F || frame_cnt !== 16'd2) begin failures++; $display("FAIL tx_other_state got=%h/%0d exp=3f/2", rx_gain, frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int s0;
        apply_reset();
        s0 = stb_count;
        for (int j = 0; j < 9; j++) send_frame(BURST[j], 16, (j == 8) ? 8 : 2);
        checks++; if (stb_count - s0 != 9) begin failures++; $display("FAIL burst_stb_count got=%0d exp=9", stb_count - s0); end
        checks++; if (frame_cnt !== 16'd9 || frame_err !== 1'b0) begin failures++; $display("FAIL burst_cnt_err got=%0d/%b exp=9/0", frame_cnt, frame_err); end
        for (int j = 0; j < 9; j++) begin
            rd_addr = BURST[j][12:8]; #1;
            checks++; if (rd_data !== BURST[j][7:0]) begin failures++; $display("FAIL burst_shadow addr=%h got=%h exp=%h", rd_addr, rd_data, BURST[j][7:0]); end
        end
        rd_addr = 5'h09; #1;
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL burst_reset_cleared got=%h exp=00", rd_data); end
    endtask

    task automatic test_short_frame();
        int s0;
        s0 = stb_count;
        send_frame(16'h0C99, 10, 8);
        rd_addr = 5'h0c; #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", frame_err); end
        checks++; if (stb_count != s0 || rd_data !== 8'h43 || frame_cnt !== 16'd9) begin failures++; $display("FAIL short_no_commit stb=%0d shadow=%h cnt=%0d exp=0/43/9", stb_count - s0, rd_data, frame_cnt); end
        send_frame(16'h0155, 16, 8);
        rd_addr = 5'h01; #1;
        checks++; if (stb_count - s0 != 1 || rd_data !== 8'h55 || frame_cnt !== 16'd10) begin failures++; $display("FAIL short_recover stb=%0d shadow=%h cnt=%0d exp=1/55/10", stb_count - s0, rd_data, frame_cnt); end
    endtask

    task automatic test_overlong_and_width();
        int s0;
        apply_reset();
        s0 = stb_count;
        send_frame(16'h0C99, 17, 8);
        rd_addr = 5'h0c; #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL overlong_err got=%b exp=1", frame_err); end
        checks++; if (stb_count != s0 || rd_data !== 8'h00 || frame_cnt !== 16'd0) begin failures++; $display("FAIL overlong_no_commit stb=%0d shadow=%h cnt=%0d exp=0/00/0", stb_count - s0, rd_data, frame_cnt); end
        send_frame(16'h0C12, 16, 8);
        #1;
        checks++; if (rd_data !== 8'h12 || frame_cnt !== 16'd1) begin failures++; $display("FAIL overlong_recover shadow=%h cnt=%0d exp=12/1", rd_data, frame_cnt); end
        apply_reset();
        s0 = stb_count;
        send_frame(16'h2C99, 16, 8);
        #1;
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL width_err got=%b exp=1", frame_err); end
        checks++; if (stb_count != s0 || rd_data !== 8'h00 || frame_cnt !== 16'd0) begin failures++; $display("FAIL width_no_commit stb=%0d shadow=%h cnt=%0d exp=0/00/0", stb_count - s0, rd_data, frame_cnt); end
    endtask

    task automatic test_read_frame();
        int s0;
        logic [7:0] exp_byte;
        apply_reset();
        send_frame(16'h0C43, 16, 8);
        s0 = stb_count;
        send_frame(16'h8C00, 16, 8);
        rd_addr = 5'h0c; #1;
        checks++; if (stb_count != s0 || frame_cnt !== 16'd1 || rd_data !== 8'h43) begin failures++; $display("FAIL read_no_commit stb=%0d cnt=%0d shadow=%h exp=0/1/43", stb_count - s0, frame_cnt, rd_data); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL read_no_err got=%b exp=0", frame_err); end
`ifdef AD9866_SPI_READBACK_EN
        exp_byte = 8'h43;
`else
        exp_byte = 8'h00;
`endif
        for (int k = 0; k < 8; k++) begin
            checks++; if (sdo_cap[8+k] !== exp_byte[7-k]) begin failures++; $display("FAIL read_sdo bit=%0d got=%b exp=%b", k, sdo_cap[8+k], exp_byte[7-k]); end
        end
        checks++; if (sdo !== 1'b0) begin failures++; $display("FAIL read_sdo_idle got=%b exp=0", sdo); end
    endtask

    task automatic test_reset_midframe();
        send_frame(16'h0654, 16, 8);
        sen_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sdio = i[0];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0; rd_addr = 5'h06; #1;
        checks++; if (rd_data !== 8'h00 || frame_cnt !== 16'd0 || wr_addr !== 5'h00) begin failures++; $display("FAIL midframe_reset shadow=%h cnt=%0d addr=%h exp=00/0/00", rd_data, frame_cnt, wr_addr); end
        sen_n = 1'b1; sdio = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h0720, 16, 8);
        rd_addr = 5'h07; #1;
        checks++; if (rd_data !== 8'h20 || frame_cnt !== 16'd1 || frame_err !== 1'b0) begin failures++; $display("FAIL midframe_recover shadow=%h cnt=%0d err=%b exp=20/1/0", rd_data, frame_cnt, frame_err); end
    endtask

    initial begin
        test_reset();
        test_write_rx_gain();
        test_write_tx_gain();
        test_back_to_back();
        test_short_frame();
        test_overlong_and_width();
        test_read_frame();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
